// File: rtl/matmul_systolic_ctrl_pkg.sv
// matmul_pkg: shared state encoding and width helpers for the systolic matmul controller.
package matmul_pkg;
   typedef enum logic [2:0] {IDLE, LOAD, FEED, DRAIN, OUT} state_t;
   function automatic int clog2w(int n);
      return n > 1 ? $clog2(n) : 1;
   endfunction
   function automatic int acc_w(int dw, int k);
      return 2 * dw + $clog2(k);
   endfunction
endpackage

// File: rtl/matmul_systolic_ctrl_if.sv
// matmul_systolic_ctrl_if: load stream, array drive and result stream of the matmul controller.
interface matmul_systolic_ctrl_if #(
   parameter int DATA_WIDTH = 8,
   parameter int M = 4,
   parameter int N = 4,
   parameter int K = 4,
   parameter int ACC_WIDTH = matmul_pkg::acc_w(DATA_WIDTH, K)
);
   logic                      i_start;
   logic                      i_load_valid;
   logic                      o_load_ready;
   logic [DATA_WIDTH-1:0]     iv_load_data;
   logic                      o_array_clr;
   logic                      o_array_en;
   logic [M*DATA_WIDTH-1:0]   ov_a;
   logic [N*DATA_WIDTH-1:0]   ov_b;
   logic [M*N*ACC_WIDTH-1:0]  iv_c;
   logic [ACC_WIDTH-1:0]      ov_c;
   logic                      o_c_valid;
   logic                      i_c_ready;
   logic                      o_busy;
   logic                      o_done;
   modport slave (
      input  i_start, i_load_valid, iv_load_data, iv_c, i_c_ready,
      output o_load_ready, o_array_clr, o_array_en, ov_a, ov_b, ov_c, o_c_valid, o_busy, o_done
   );
   modport master (
      output i_start, i_load_valid, iv_load_data, iv_c, i_c_ready,
      input  o_load_ready, o_array_clr, o_array_en, ov_a, ov_b, ov_c, o_c_valid, o_busy, o_done
   );
endinterface

// File: rtl/matmul_systolic_ctrl_bank.sv
// operand_bank: 1-write/1-read RAM with a registered read port, one per array lane.
module operand_bank #(
   parameter int DW = 8,
   parameter int DEPTH = 4,
   parameter int AW = 2
) (
   input  logic          i_clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);
   logic [DW-1:0] mem [DEPTH];
   always_ff @(posedge i_clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end
endmodule

// File: rtl/matmul_systolic_ctrl.sv
// matmul_systolic_ctrl: loads A/B into lane banks, feeds them skewed to the array, then streams results.
module matmul_systolic_ctrl
   import matmul_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int M = 4,
   parameter int N = 4,
   parameter int K = 4,
   parameter int DRAIN_CYCLES = 2,
   parameter int ACC_WIDTH = acc_w(DATA_WIDTH, K)
) (
   input logic i_clk,
   input logic i_rst_n,
   matmul_systolic_ctrl_if.slave bus
);
   localparam int T = K + M + N - 2;
   localparam int MX0 = T > M * N ? T : M * N;
   localparam int MX = MX0 > DRAIN_CYCLES ? MX0 : DRAIN_CYCLES;
   localparam int CW = clog2w(MX + 1);
   localparam int AW = clog2w(K);
   localparam int LW = clog2w(M + N);

   state_t                state;
   logic [CW-1:0]         cnt, ft;
   logic [AW-1:0]         ld_addr;
   logic [LW-1:0]         ld_lane;
   logic                  ld_fire, ld_last, iss;
   logic [M-1:0]          a_re, a_vld;
   logic [N-1:0]          b_re, b_vld;
   logic [AW-1:0]         a_ra [M];
   logic [AW-1:0]         b_ra [N];
   logic [DATA_WIDTH-1:0] a_rd [M];
   logic [DATA_WIDTH-1:0] b_rd [N];

   // Banks 0..M-1 hold A rows, M..M+N-1 hold B columns; each takes K consecutive words.
   assign ld_fire = bus.i_load_valid && bus.o_load_ready;
   assign ld_last = ld_lane == LW'(M + N - 1) && ld_addr == AW'(K - 1);
   assign bus.o_array_clr = ld_fire && ld_last;
   // Reads run one step ahead of the feed counter: ft is the step whose operands are fetched now.
   assign iss = bus.o_array_clr || (state == FEED && cnt != CW'(T - 1));
   assign ft = state == FEED ? cnt + CW'(1) : '0;

   always_comb begin
      a_re = '0;
      b_re = '0;
      a_ra = '{default: '0};
      b_ra = '{default: '0};
      bus.ov_a = '0;
      bus.ov_b = '0;
      bus.ov_c = '0;
      for (int i = 0; i < M; i++) begin
         a_re[i] = iss && ft >= CW'(i) && ft - CW'(i) < CW'(K);
         a_ra[i] = AW'(ft - CW'(i));
         bus.ov_a[i*DATA_WIDTH +: DATA_WIDTH] = a_vld[i] ? a_rd[i] : '0;
      end
      for (int j = 0; j < N; j++) begin
         b_re[j] = iss && ft >= CW'(j) && ft - CW'(j) < CW'(K);
         b_ra[j] = AW'(ft - CW'(j));
         bus.ov_b[j*DATA_WIDTH +: DATA_WIDTH] = b_vld[j] ? b_rd[j] : '0;
      end
      for (int e = 0; e < M * N; e++)
         if (bus.o_c_valid && cnt == CW'(e)) bus.ov_c = bus.iv_c[e*ACC_WIDTH +: ACC_WIDTH];
   end

   for (genvar i = 0; i < M; i++) begin : g_bank_a
      operand_bank #(.DW(DATA_WIDTH), .DEPTH(K), .AW(AW)) u_bank (
         .i_clk, .we(ld_fire && ld_lane == LW'(i)), .waddr(ld_addr), .wdata(bus.iv_load_data),
         .re(a_re[i]), .raddr(a_ra[i]), .rdata(a_rd[i])
      );
   end
   for (genvar j = 0; j < N; j++) begin : g_bank_b
      operand_bank #(.DW(DATA_WIDTH), .DEPTH(K), .AW(AW)) u_bank (
         .i_clk, .we(ld_fire && ld_lane == LW'(M + j)), .waddr(ld_addr), .wdata(bus.iv_load_data),
         .re(b_re[j]), .raddr(b_ra[j]), .rdata(b_rd[j])
      );
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= IDLE;
         cnt <= '0;
         ld_addr <= '0;
         ld_lane <= '0;
         a_vld <= '0;
         b_vld <= '0;
         bus.o_load_ready <= 1'b0;
         bus.o_array_en <= 1'b0;
         bus.o_c_valid <= 1'b0;
         bus.o_busy <= 1'b0;
         bus.o_done <= 1'b0;
      end else begin
         a_vld <= a_re;
         b_vld <= b_re;
         bus.o_done <= 1'b0;
         case (state)
            IDLE: if (bus.i_start && !bus.o_done) begin
               state <= LOAD;
               bus.o_load_ready <= 1'b1;
               bus.o_busy <= 1'b1;
            end
            LOAD: if (ld_fire) begin
               ld_addr <= ld_addr == AW'(K - 1) ? '0 : ld_addr + AW'(1);
               ld_lane <= ld_addr == AW'(K - 1) ? ld_lane + LW'(1) : ld_lane;
               if (ld_last) begin
                  state <= FEED;
                  ld_lane <= '0;
                  bus.o_load_ready <= 1'b0;
                  bus.o_array_en <= 1'b1;
               end
            end
            FEED: begin
               cnt <= cnt == CW'(T - 1) ? '0 : cnt + CW'(1);
               if (cnt == CW'(T - 1)) state <= DRAIN;
            end
            DRAIN: begin
               cnt <= cnt == CW'(DRAIN_CYCLES - 1) ? '0 : cnt + CW'(1);
               if (cnt == CW'(DRAIN_CYCLES - 1)) begin
                  state <= OUT;
                  bus.o_array_en <= 1'b0;
                  bus.o_c_valid <= 1'b1;
               end
            end
            OUT: if (bus.i_c_ready) begin
               cnt <= cnt == CW'(M * N - 1) ? '0 : cnt + CW'(1);
               if (cnt == CW'(M * N - 1)) begin
                  state <= IDLE;
                  bus.o_c_valid <= 1'b0;
                  bus.o_busy <= 1'b0;
                  bus.o_done <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_matmul_systolic_ctrl.sv
// tb_matmul_systolic_ctrl: drives jobs through the controller into a behavioural systolic array
// and compares the streamed results with plain matrix products.
module tb_matmul_systolic_ctrl;
   import matmul_pkg::*;
   localparam int DW = 8, M = 2, N = 3, K = 4, D = 2;
   localparam int ACC = acc_w(DW, K);
   localparam int T = K + M + N - 2;
   localparam int L = M * K + K * N;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   matmul_systolic_ctrl_if #(.DATA_WIDTH(DW), .M(M), .N(N), .K(K), .ACC_WIDTH(ACC)) bus ();
   matmul_systolic_ctrl #(.DATA_WIDTH(DW), .M(M), .N(N), .K(K), .DRAIN_CYCLES(D), .ACC_WIDTH(ACC)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .bus(bus)
   );

   logic [DW-1:0]  ga [M][K];
   logic [DW-1:0]  gb [K][N];
   int             ec [M][N];
   logic [ACC-1:0] acc [M][N];
   logic [DW-1:0]  ar [M][N];
   logic [DW-1:0]  br [M][N];
   int clr_cnt = 0;
   int n_pass = 0;
   int n_tot = 0;

   typedef struct {
      logic [M*K*DW-1:0]  a;
      logic [K*N*DW-1:0]  b;
      logic [M*N*ACC-1:0] c;
      bit stall, bp, poke;
   } vec_t;
   vec_t vecs [4];

   // Downstream array: A flows right, B flows down, each PE accumulates its product.
   function automatic logic [DW-1:0] a_in(int i, int j);
      return j == 0 ? bus.ov_a[i*DW +: DW] : ar[i][j-1];
   endfunction
   function automatic logic [DW-1:0] b_in(int i, int j);
      return i == 0 ? bus.ov_b[j*DW +: DW] : br[i-1][j];
   endfunction

   always @(posedge clk)
      for (int i = 0; i < M; i++)
         for (int j = 0; j < N; j++)
            if (bus.o_array_clr) begin
               acc[i][j] <= '0;
               ar[i][j] <= '0;
               br[i][j] <= '0;
            end else if (bus.o_array_en) begin
               acc[i][j] <= acc[i][j] + ACC'(a_in(i, j)) * ACC'(b_in(i, j));
               ar[i][j] <= a_in(i, j);
               br[i][j] <= b_in(i, j);
            end

   always_comb begin
      bus.iv_c = '0;
      for (int i = 0; i < M; i++)
         for (int j = 0; j < N; j++) bus.iv_c[(i*N+j)*ACC +: ACC] = acc[i][j];
   end

   always @(negedge clk) if (bus.o_array_clr) clr_cnt <= clr_cnt + 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input longint act, input longint exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
   endtask

   function automatic logic [DW-1:0] word(int w);
      int ln = w / K;
      int ad = w % K;
      return ln < M ? ga[ln][ad] : gb[ad][ln-M];
   endfunction

   function automatic logic [M*DW-1:0] exp_a(int t);
      logic [M*DW-1:0] r = '0;
      for (int i = 0; i < M; i++) if (t - i >= 0 && t - i < K) r[i*DW +: DW] = ga[i][t-i];
      return r;
   endfunction

   function automatic logic [N*DW-1:0] exp_b(int t);
      logic [N*DW-1:0] r = '0;
      for (int j = 0; j < N; j++) if (t - j >= 0 && t - j < K) r[j*DW +: DW] = gb[t-j][j];
      return r;
   endfunction

   task automatic model();
      for (int i = 0; i < M; i++)
         for (int j = 0; j < N; j++) begin
            ec[i][j] = 0;
            for (int k = 0; k < K; k++) ec[i][j] += int'(ga[i][k]) * int'(gb[k][j]);
         end
   endtask

   task automatic randomize_job();
      for (int i = 0; i < M; i++) for (int k = 0; k < K; k++) ga[i][k] = DW'($urandom);
      for (int k = 0; k < K; k++) for (int j = 0; j < N; j++) gb[k][j] = DW'($urandom);
      model();
   endtask

   task automatic load_job(input bit stall, output int cyc);
      bus.i_start = 1'b1;
      tick();
      bus.i_start = 1'b0;
      cyc = 1;
      chk("load_ready", longint'(bus.o_load_ready), 1);
      for (int w = 0; w < L; w++) begin
         if (stall) begin
            bus.i_load_valid = 1'b0;
            tick();
            cyc++;
         end
         bus.i_load_valid = 1'b1;
         bus.iv_load_data = word(w);
         tick();
         cyc++;
      end
      bus.i_load_valid = 1'b0;
   endtask

   task automatic run_job(input bit stall, input bit bp, input bit poke);
      int cyc, wn, c0;
      c0 = clr_cnt;
      chk("idle_busy", longint'(bus.o_busy), 0);
      load_job(stall, cyc);
      wn = 0;
      while (!bus.o_c_valid && wn < 200) begin
         chk("feed_a", longint'(bus.ov_a), longint'(exp_a(wn)));
         chk("feed_b", longint'(bus.ov_b), longint'(exp_b(wn)));
         chk("array_en", longint'(bus.o_array_en), 1);
         bus.i_start = poke && wn == 2;
         tick();
         cyc++;
         wn++;
      end
      bus.i_start = 1'b0;
      if (!bus.o_c_valid) begin
         chk("out_valid_timeout", 0, 1);
         return;
      end
      chk("feed_drain_len", wn, T + D);
      chk("out_en_low", longint'(bus.o_array_en), 0);
      for (int k = 0; k < M * N; k++) begin
         if (bp && k == 2) begin
            bus.i_c_ready = 1'b0;
            for (int s = 0; s < 5; s++) begin
               tick();
               cyc++;
               chk("bp_hold_data", longint'(bus.ov_c), ec[k/N][k%N]);
               chk("bp_hold_valid", longint'(bus.o_c_valid), 1);
            end
            bus.i_c_ready = 1'b1;
         end
         chk("c_valid", longint'(bus.o_c_valid), 1);
         chk("c_data", longint'(bus.ov_c), ec[k/N][k%N]);
         bus.i_start = poke && k == 1;
         tick();
         cyc++;
         bus.i_start = 1'b0;
      end
      chk("done_pulse", longint'(bus.o_done), 1);
      chk("done_c_valid_low", longint'(bus.o_c_valid), 0);
      if (!stall && !bp) chk("latency", cyc, 1 + L + T + D + M * N);
      chk("clr_once", clr_cnt - c0, 1);
      bus.i_start = poke;
      tick();
      bus.i_start = 1'b0;
      chk("done_low", longint'(bus.o_done), 0);
      chk("idle_after", longint'(bus.o_busy), 0);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"}, longint'(bus.o_busy), 0);
      chk({tag, "_ready"}, longint'(bus.o_load_ready), 0);
      chk({tag, "_en"}, longint'(bus.o_array_en), 0);
      chk({tag, "_clr"}, longint'(bus.o_array_clr), 0);
      chk({tag, "_cvalid"}, longint'(bus.o_c_valid), 0);
      chk({tag, "_done"}, longint'(bus.o_done), 0);
      chk({tag, "_a"}, longint'(bus.ov_a), 0);
      chk({tag, "_b"}, longint'(bus.ov_b), 0);
      chk({tag, "_c"}, longint'(bus.ov_c), 0);
   endtask

   initial begin
      int cyc;
      bus.i_start = 1'b0;
      bus.i_load_valid = 1'b0;
      bus.iv_load_data = '0;
      bus.i_c_ready = 1'b1;
      tick();
      tick();
      chk_zero("reset");
      rst_n = 1'b1;
      tick();

      // A row-major, B row-major in the packed literals; element 0 is the rightmost field.
      vecs[0] = '{a: {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1},
                  b: {8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1},
                  c: {18'd7, 18'd6, 18'd5, 18'd3, 18'd2, 18'd1}, stall: 0, bp: 0, poke: 0};
      vecs[1] = '{a: {8{8'd1}}, b: {12{8'd2}}, c: {6{18'd8}}, stall: 1, bp: 0, poke: 0};
      vecs[2] = '{a: {8{8'd255}}, b: {12{8'd255}}, c: {6{18'd260100}}, stall: 0, bp: 1, poke: 0};
      vecs[3] = '{a: {8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1},
                  b: {8'd12, 8'd11, 8'd10, 8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1},
                  c: {18'd12, 18'd11, 18'd10, 18'd3, 18'd2, 18'd1}, stall: 0, bp: 0, poke: 1};
      for (int v = 0; v < 4; v++) begin
         for (int i = 0; i < M; i++) for (int k = 0; k < K; k++) ga[i][k] = vecs[v].a[(i*K+k)*DW +: DW];
         for (int k = 0; k < K; k++) for (int j = 0; j < N; j++) gb[k][j] = vecs[v].b[(k*N+j)*DW +: DW];
         for (int i = 0; i < M; i++) for (int j = 0; j < N; j++) ec[i][j] = int'(vecs[v].c[(i*N+j)*ACC +: ACC]);
         run_job(vecs[v].stall, vecs[v].bp, vecs[v].poke);
      end

      for (int r = 0; r < 6; r++) begin
         randomize_job();
         run_job(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      randomize_job();
      load_job(1'b0, cyc);
      tick();
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      chk_zero("midfeed_rst");
      tick();
      rst_n = 1'b1;
      tick();
      chk_zero("after_rst");
      randomize_job();
      run_job(1'b0, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
